// File: rtl/tdm_voice_mixer_dac.sv
// Sums one TDM frame of voice samples into a scaled, saturated mix sample
// and drives a first-order delta-sigma 1-bit DAC from the latest mix.
module tdm_voice_mixer_dac #(
  parameter int D_W        = 16,
  parameter int NUM_VOICES = 4,
  parameter int CH_W       = 2,
  parameter int GAIN_SHIFT = 2
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic            tdm_valid,
  input  logic [D_W-1:0]  tdm_voice_data,
  input  logic [CH_W-1:0] tdm_channel,
  input  logic            tdm_chan_enabled,
  output logic [D_W-1:0]  mix_sample,
  output logic            mix_valid,
  output logic            frame_err,
  output logic            dac_out
);

  localparam int A_W = D_W + CH_W;
  localparam logic [CH_W-1:0]       LAST_CH = CH_W'(NUM_VOICES - 1);
  localparam logic signed [A_W-1:0] SAT_MAX = A_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [A_W-1:0] SAT_MIN = -SAT_MAX - A_W'(1);

  logic signed [A_W-1:0] acc_q, acc_d;
  logic signed [A_W-1:0] slot_val, final_sum, shifted;
  logic [CH_W-1:0]       exp_q, exp_d;
  logic                  resync_q, resync_d;
  logic [D_W-1:0]        mix_q, mix_d;
  logic                  mix_valid_q, mix_valid_d;
  logic                  err_q, err_d;
  logic [D_W:0]          integ_q, integ_d;
  logic                  dac_q, dac_d;
  logic [D_W-1:0]        u;

  always_comb begin
    acc_d       = acc_q;
    exp_d       = exp_q;
    resync_d    = resync_q;
    mix_d       = mix_q;
    mix_valid_d = 1'b0;
    err_d       = 1'b0;
    slot_val    = tdm_chan_enabled ? {{CH_W{tdm_voice_data[D_W-1]}}, tdm_voice_data} : '0;
    final_sum   = (tdm_channel == '0) ? slot_val : acc_q + slot_val;
    shifted     = final_sum >>> GAIN_SHIFT;

    if (tdm_valid) begin
      // Once a frame is dropped, further stray slots are ignored silently
      // until slot 0 resynchronises, so one break yields one frame_err pulse.
      if (tdm_channel == exp_q || tdm_channel == '0) begin
        err_d    = (tdm_channel != exp_q) && !resync_q;
        resync_d = 1'b0;
        acc_d    = final_sum;
        exp_d    = tdm_channel + CH_W'(1);
        if (tdm_channel == LAST_CH) begin
          exp_d       = '0;
          mix_valid_d = 1'b1;
          if (shifted > SAT_MAX)      mix_d = SAT_MAX[D_W-1:0];
          else if (shifted < SAT_MIN) mix_d = SAT_MIN[D_W-1:0];
          else                        mix_d = shifted[D_W-1:0];
        end
      end else begin
        err_d    = !resync_q;
        resync_d = 1'b1;
        exp_d    = '0;
      end
    end
  end

  // Offset-binary input; dropping the old carry makes the error-feedback loop.
  always_comb begin
    u       = {~mix_q[D_W-1], mix_q[D_W-2:0]};
    integ_d = {1'b0, integ_q[D_W-1:0]} + {1'b0, u};
    dac_d   = integ_d[D_W];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      exp_q       <= '0;
      resync_q    <= 1'b0;
      mix_q       <= '0;
      mix_valid_q <= 1'b0;
      err_q       <= 1'b0;
      integ_q     <= '0;
      dac_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      exp_q       <= exp_d;
      resync_q    <= resync_d;
      mix_q       <= mix_d;
      mix_valid_q <= mix_valid_d;
      err_q       <= err_d;
      integ_q     <= integ_d;
      dac_q       <= dac_d;
    end
  end

  assign mix_sample = mix_q;
  assign mix_valid  = mix_valid_q;
  assign frame_err  = err_q;
  assign dac_out    = dac_q;

endmodule

// File: tb/tb_tdm_voice_mixer_dac.sv
// Directed bench: two mixers (GAIN_SHIFT 2 and 0) share one TDM stream.
module tb_tdm_voice_mixer_dac;

  logic        sys_clk = 1'b0;
  logic        rst_n   = 1'b1;
  logic        tdm_valid = 1'b0;
  logic [15:0] tdm_voice_data = '0;
  logic [1:0]  tdm_channel = '0;
  logic        tdm_chan_enabled = 1'b0;

  logic [15:0] ms2, ms0;
  logic        mv2, mv0, fe2, fe0, dac2, dac0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 sys_clk = ~sys_clk;

  tdm_voice_mixer_dac #(.D_W(16), .NUM_VOICES(4), .CH_W(2), .GAIN_SHIFT(2)) u_dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .tdm_valid(tdm_valid),
    .tdm_voice_data(tdm_voice_data), .tdm_channel(tdm_channel),
    .tdm_chan_enabled(tdm_chan_enabled), .mix_sample(ms2), .mix_valid(mv2),
    .frame_err(fe2), .dac_out(dac2));

  tdm_voice_mixer_dac #(.D_W(16), .NUM_VOICES(4), .CH_W(2), .GAIN_SHIFT(0)) u_dut0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .tdm_valid(tdm_valid),
    .tdm_voice_data(tdm_voice_data), .tdm_channel(tdm_channel),
    .tdm_chan_enabled(tdm_chan_enabled), .mix_sample(ms0), .mix_valid(mv0),
    .frame_err(fe0), .dac_out(dac0));

  typedef struct {
    string           name;
    logic [3:0][15:0] d;
    logic [3:0]      en;
    int              gap;
    logic [15:0]     e2;
    logic [15:0]     e0;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [15:0] d, input logic en);
    @(negedge sys_clk);
    tdm_valid        = v;
    tdm_channel      = ch;
    tdm_voice_data   = d;
    tdm_chan_enabled = en;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 2'd0, 16'h0000, 1'b0);
  endtask

  task automatic run_frame(input vec_t v);
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, 2'(s), v.d[s], v.en[s]);
      if (s < 3) begin
        idle(v.gap);
        if (v.gap > 0) chk({v.name, " no early valid"}, {31'b0, mv2}, 32'd0);
      end
    end
    idle(1);
    chk({v.name, " mv2"}, {31'b0, mv2}, 32'd1);
    chk({v.name, " mv0"}, {31'b0, mv0}, 32'd1);
    chk({v.name, " ms2"}, {16'b0, ms2}, {16'b0, v.e2});
    chk({v.name, " ms0"}, {16'b0, ms0}, {16'b0, v.e0});
    idle(1);
    chk({v.name, " mv2 one cycle"}, {31'b0, mv2}, 32'd0);
    chk({v.name, " ms2 hold"}, {16'b0, ms2}, {16'b0, v.e2});
  endtask

  task automatic count_dac(input int n, output int c2, output int c0);
    c2 = 0;
    c0 = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge sys_clk);
      c2 += int'(dac2);
      c0 += int'(dac0);
    end
  endtask

  initial begin
    int c2, c0;

    vecs[0] = '{"pos2000",  {16'h2000, 16'h2000, 16'h2000, 16'h2000}, 4'b1111, 0, 16'h2000, 16'h7FFF};
    vecs[1] = '{"max",      {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 4'b1111, 0, 16'h7FFF, 16'h7FFF};
    vecs[2] = '{"min",      {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 4'b1111, 0, 16'h8000, 16'h8000};
    vecs[3] = '{"mixed",    {16'h8000, 16'h0100, 16'hF000, 16'h1234}, 4'b1111, 0, 16'hE0CD, 16'h8334};
    vecs[4] = '{"floor",    {16'h0000, 16'h0000, 16'h0000, 16'hFFFD}, 4'b1111, 2, 16'hFFFF, 16'hFFFD};
    vecs[5] = '{"dis2",     {16'h4000, 16'h7FFF, 16'h4000, 16'h4000}, 4'b1011, 0, 16'h3000, 16'h7FFF};
    vecs[6] = '{"dis2gap",  {16'h4000, 16'h7FFF, 16'h4000, 16'h4000}, 4'b1011, 5, 16'h3000, 16'h7FFF};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst ms2", {16'b0, ms2}, 32'd0);
    chk("rst mv2", {31'b0, mv2}, 32'd0);
    chk("rst fe2", {31'b0, fe2}, 32'd0);
    chk("rst dac2", {31'b0, dac2}, 32'd0);
    rst_n = 1'b1;

    count_dac(1024, c2, c0);
    chk_rng("idle dac2 ones", c2, 511, 513);
    chk_rng("idle dac0 ones", c0, 511, 513);

    foreach (vecs[i]) run_frame(vecs[i]);

    count_dac(1024, c2, c0);
    chk_rng("dac2 ones u=B000", c2, 703, 705);
    chk_rng("dac0 ones u=FFFF", c0, 1023, 1024);

    // Out-of-sequence channel 3 after slots 0,1.
    drive(1'b1, 2'd0, 16'h1000, 1'b1);
    drive(1'b1, 2'd1, 16'h1000, 1'b1);
    drive(1'b1, 2'd3, 16'h5555, 1'b1);
    idle(1);
    chk("oos fe2", {31'b0, fe2}, 32'd1);
    chk("oos fe0", {31'b0, fe0}, 32'd1);
    chk("oos mv2", {31'b0, mv2}, 32'd0);
    idle(1);
    chk("oos fe2 one cycle", {31'b0, fe2}, 32'd0);
    chk("oos ms2 hold", {16'b0, ms2}, 32'h3000);
    run_frame('{"clean1000", {16'h1000, 16'h1000, 16'h1000, 16'h1000}, 4'b1111, 0, 16'h1000, 16'h4000});

    // Slot 0 mid-frame restarts the frame.
    drive(1'b1, 2'd0, 16'h7000, 1'b1);
    drive(1'b1, 2'd1, 16'h7000, 1'b1);
    drive(1'b1, 2'd0, 16'h0400, 1'b1);
    drive(1'b1, 2'd1, 16'h0400, 1'b1);
    chk("restart fe2", {31'b0, fe2}, 32'd1);
    drive(1'b1, 2'd2, 16'h0400, 1'b1);
    chk("restart fe2 clear", {31'b0, fe2}, 32'd0);
    drive(1'b1, 2'd3, 16'h0400, 1'b1);
    idle(1);
    chk("restart mv2", {31'b0, mv2}, 32'd1);
    chk("restart ms2", {16'b0, ms2}, 32'h0400);
    chk("restart ms0", {16'b0, ms0}, 32'h1000);

    // Async reset between slot 1 and slot 2.
    drive(1'b1, 2'd0, 16'h1111, 1'b1);
    drive(1'b1, 2'd1, 16'h2222, 1'b1);
    idle(1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ms2", {16'b0, ms2}, 32'd0);
    chk("async rst ms0", {16'b0, ms0}, 32'd0);
    chk("async rst dac2", {31'b0, dac2}, 32'd0);
    chk("async rst mv2", {31'b0, mv2}, 32'd0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd2, 16'h3333, 1'b1);
    drive(1'b1, 2'd3, 16'h4444, 1'b1);
    chk("post rst fe2 slot2", {31'b0, fe2}, 32'd1);
    idle(1);
    chk("post rst fe2 slot3", {31'b0, fe2}, 32'd0);
    chk("post rst mv2", {31'b0, mv2}, 32'd0);
    idle(2);
    chk("post rst ms2", {16'b0, ms2}, 32'd0);
    chk("post rst mv0", {31'b0, mv0}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
